// File: rtl/issue_scheduler.sv
// issue_scheduler: classifies RV32IMF instruction words to ALU/MDU/FPU/LSU,
// tracks pending int/fp destinations in two scoreboards, stalls on RAW/WAW
// hazards and dispatches through a one-entry registered buffer.
// Optional macro ISSUE_WB_BYPASS_EN: same-cycle writebacks are removed from
// the hazard check, saving one bubble after writeback.
module issue_scheduler #(
   parameter bit FENCE_DRAIN = 1'b1,
   parameter bit FPU_PRESENT = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        instr_valid_i,
   input  logic [31:0] instr_i,
   output logic        instr_ready_o,
   output logic        disp_valid_o,
   output logic [3:0]  disp_unit_o,
   output logic [31:0] disp_instr_o,
   input  logic [3:0]  unit_ready_i,
   input  logic        wb_int_valid_i,
   input  logic [4:0]  wb_int_rd_i,
   input  logic        wb_fp_valid_i,
   input  logic [4:0]  wb_fp_rd_i,
   input  logic        flush_i,
   output logic        illegal_o,
   output logic        sb_busy_o
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_ALU_I  = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_ECSR   = 7'b1110011;
   localparam logic [6:0] OP_FLOAD  = 7'b0000111;
   localparam logic [6:0] OP_FSTORE = 7'b0100111;
   localparam logic [6:0] OP_FMADD  = 7'b1000011;
   localparam logic [6:0] OP_FMSUB  = 7'b1000111;
   localparam logic [6:0] OP_FNMSUB = 7'b1001011;
   localparam logic [6:0] OP_FNMADD = 7'b1001111;
   localparam logic [6:0] OP_F_OPS  = 7'b1010011;

   localparam logic [6:0] F7_MULDIV  = 7'b0000001;
   localparam logic [6:0] F7_FADD    = 7'b0000000;
   localparam logic [6:0] F7_FSUB    = 7'b0000100;
   localparam logic [6:0] F7_FMUL    = 7'b0001000;
   localparam logic [6:0] F7_FDIV    = 7'b0001100;
   localparam logic [6:0] F7_FSGN    = 7'b0010000;
   localparam logic [6:0] F7_FLIM    = 7'b0010100;
   localparam logic [6:0] F7_FCMP    = 7'b1010000;
   localparam logic [6:0] F7_FCVTW   = 7'b1100000;
   localparam logic [6:0] F7_FMV_CLS = 7'b1110000;
   localparam logic [6:0] F7_FCVTS   = 7'b1101000;
   localparam logic [6:0] F7_FMVWX   = 7'b1111000;

   localparam logic [3:0] U_ALU = 4'b0001;
   localparam logic [3:0] U_MDU = 4'b0010;
   localparam logic [3:0] U_FPU = 4'b0100;
   localparam logic [3:0] U_LSU = 4'b1000;

   logic [6:0]  opcode_s, funct7_s;
   logic [2:0]  funct3_s;
   logic [4:0]  rd_s, rs1_s, rs2_s, rs3_s;
   logic        legal_s, is_fence_s;
   logic [3:0]  unit_s;
   logic        use_irs1_s, use_irs2_s, use_frs1_s, use_frs2_s, use_frs3_s;
   logic        wr_int_raw_s, wr_int_s, wr_fp_s;

   logic [31:0] sb_int_r, sb_fp_r, sb_int_nxt_s, sb_fp_nxt_s;
   logic [31:0] sb_int_chk_s, sb_fp_chk_s;
   logic        disp_valid_r, buf_wr_int_r, buf_wr_fp_r, illegal_r;
   logic [3:0]  disp_unit_r;
   logic [31:0] disp_instr_r;
   logic        drain_s, free_s, hazard_s, fence_block_s, busy_s;
   logic        accept_s, accept_legal_s;

   assign opcode_s = instr_i[6:0];
   assign rd_s     = instr_i[11:7];
   assign funct3_s = instr_i[14:12];
   assign rs1_s    = instr_i[19:15];
   assign rs2_s    = instr_i[24:20];
   assign funct7_s = instr_i[31:25];
   assign rs3_s    = instr_i[31:27];

   // Decode: legality, target unit, source usage and destination class.
   always_comb begin
      legal_s = 1'b0; is_fence_s = 1'b0; unit_s = 4'b0000;
      use_irs1_s = 1'b0; use_irs2_s = 1'b0;
      use_frs1_s = 1'b0; use_frs2_s = 1'b0; use_frs3_s = 1'b0;
      wr_int_raw_s = 1'b0; wr_fp_s = 1'b0;
      case (opcode_s)
         OP_LUI, OP_AUIPC, OP_JAL: begin
            legal_s = 1'b1; unit_s = U_ALU; wr_int_raw_s = 1'b1;
         end
         OP_JALR, OP_ALU_I: begin
            legal_s = 1'b1; unit_s = U_ALU; use_irs1_s = 1'b1; wr_int_raw_s = 1'b1;
         end
         OP_BRANCH: begin
            legal_s = 1'b1; unit_s = U_ALU; use_irs1_s = 1'b1; use_irs2_s = 1'b1;
         end
         OP_LOAD: begin
            legal_s = 1'b1; unit_s = U_LSU; use_irs1_s = 1'b1; wr_int_raw_s = 1'b1;
         end
         OP_STORE: begin
            legal_s = 1'b1; unit_s = U_LSU; use_irs1_s = 1'b1; use_irs2_s = 1'b1;
         end
         OP_REG: begin
            legal_s = 1'b1; use_irs1_s = 1'b1; use_irs2_s = 1'b1; wr_int_raw_s = 1'b1;
            if (funct7_s == F7_MULDIV) begin
               unit_s = U_MDU;
            end else begin
               unit_s = U_ALU;
            end
         end
         OP_FENCE: begin
            legal_s = 1'b1; unit_s = U_ALU; is_fence_s = 1'b1;
         end
         OP_ECSR: begin
            legal_s = 1'b1; unit_s = U_ALU; is_fence_s = 1'b1;
            use_irs1_s = (funct3_s == 3'b001) || (funct3_s == 3'b010) || (funct3_s == 3'b011);
            wr_int_raw_s = (funct3_s != 3'b000);
         end
         OP_FLOAD: begin
            legal_s = FPU_PRESENT; unit_s = U_LSU; use_irs1_s = 1'b1; wr_fp_s = 1'b1;
         end
         OP_FSTORE: begin
            legal_s = FPU_PRESENT; unit_s = U_LSU; use_irs1_s = 1'b1; use_frs2_s = 1'b1;
         end
         OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD: begin
            legal_s = FPU_PRESENT; unit_s = U_FPU; wr_fp_s = 1'b1;
            use_frs1_s = 1'b1; use_frs2_s = 1'b1; use_frs3_s = 1'b1;
         end
         OP_F_OPS: begin
            legal_s = FPU_PRESENT; unit_s = U_FPU;
            case (funct7_s)
               F7_FCVTS, F7_FMVWX: begin
                  use_irs1_s = 1'b1; wr_fp_s = 1'b1;
               end
               F7_FCVTW, F7_FMV_CLS: begin
                  use_frs1_s = 1'b1; wr_int_raw_s = 1'b1;
               end
               F7_FCMP: begin
                  use_frs1_s = 1'b1; use_frs2_s = 1'b1; wr_int_raw_s = 1'b1;
               end
               F7_FADD, F7_FSUB, F7_FMUL, F7_FDIV, F7_FSGN, F7_FLIM: begin
                  use_frs1_s = 1'b1; use_frs2_s = 1'b1; wr_fp_s = 1'b1;
               end
               default: begin
                  use_frs1_s = 1'b1; wr_fp_s = 1'b1;
               end
            endcase
         end
         default: begin
            legal_s = 1'b0;
         end
      endcase
   end

   assign wr_int_s = wr_int_raw_s && (rd_s != 5'd0);

   // Scoreboard view used for hazards; with bypass, this cycle's writeback is already gone.
   always_comb begin
      sb_int_chk_s = sb_int_r;
      sb_fp_chk_s  = sb_fp_r;
`ifdef ISSUE_WB_BYPASS_EN
      if (wb_int_valid_i) begin
         sb_int_chk_s[wb_int_rd_i] = 1'b0;
      end else begin
         sb_int_chk_s = sb_int_r;
      end
      if (wb_fp_valid_i) begin
         sb_fp_chk_s[wb_fp_rd_i] = 1'b0;
      end else begin
         sb_fp_chk_s = sb_fp_r;
      end
`endif
   end

   assign busy_s   = (|sb_int_r) | (|sb_fp_r);
   assign drain_s  = disp_valid_r & (|(disp_unit_r & unit_ready_i));
   assign free_s   = ~disp_valid_r | drain_s;
   assign hazard_s = legal_s & ((use_irs1_s & sb_int_chk_s[rs1_s]) |
                                (use_irs2_s & sb_int_chk_s[rs2_s]) |
                                (use_frs1_s & sb_fp_chk_s[rs1_s])  |
                                (use_frs2_s & sb_fp_chk_s[rs2_s])  |
                                (use_frs3_s & sb_fp_chk_s[rs3_s])  |
                                (wr_int_s   & sb_int_chk_s[rd_s])  |
                                (wr_fp_s    & sb_fp_chk_s[rd_s]));
   assign fence_block_s  = FENCE_DRAIN & legal_s & is_fence_s & (busy_s | disp_valid_r);
   assign instr_ready_o  = rst_n_i & free_s & ~hazard_s & ~flush_i & ~fence_block_s;
   assign accept_s       = instr_valid_i & instr_ready_o;
   assign accept_legal_s = accept_s & legal_s;
   assign sb_busy_o      = busy_s;

   // Scoreboard next state: writeback and flush clear, accepted destination sets (set wins).
   always_comb begin
      sb_int_nxt_s = sb_int_r;
      sb_fp_nxt_s  = sb_fp_r;
      if (wb_int_valid_i) begin
         sb_int_nxt_s[wb_int_rd_i] = 1'b0;
      end else begin
         sb_int_nxt_s = sb_int_nxt_s;
      end
      if (wb_fp_valid_i) begin
         sb_fp_nxt_s[wb_fp_rd_i] = 1'b0;
      end else begin
         sb_fp_nxt_s = sb_fp_nxt_s;
      end
      if (flush_i && disp_valid_r && !drain_s) begin
         if (buf_wr_int_r) begin
            sb_int_nxt_s[disp_instr_r[11:7]] = 1'b0;
         end else begin
            sb_int_nxt_s = sb_int_nxt_s;
         end
         if (buf_wr_fp_r) begin
            sb_fp_nxt_s[disp_instr_r[11:7]] = 1'b0;
         end else begin
            sb_fp_nxt_s = sb_fp_nxt_s;
         end
      end else begin
         sb_int_nxt_s = sb_int_nxt_s;
      end
      if (accept_legal_s && wr_int_s) begin
         sb_int_nxt_s[rd_s] = 1'b1;
      end else begin
         sb_int_nxt_s = sb_int_nxt_s;
      end
      if (accept_legal_s && wr_fp_s) begin
         sb_fp_nxt_s[rd_s] = 1'b1;
      end else begin
         sb_fp_nxt_s = sb_fp_nxt_s;
      end
      sb_int_nxt_s[0] = 1'b0;
   end

   // State registers: scoreboards, dispatch buffer and illegal pulse.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sb_int_r     <= 32'd0;
         sb_fp_r      <= 32'd0;
         disp_valid_r <= 1'b0;
         disp_unit_r  <= 4'd0;
         disp_instr_r <= 32'd0;
         buf_wr_int_r <= 1'b0;
         buf_wr_fp_r  <= 1'b0;
         illegal_r    <= 1'b0;
      end else begin
         sb_int_r  <= sb_int_nxt_s;
         sb_fp_r   <= sb_fp_nxt_s;
         illegal_r <= accept_s & ~legal_s;
         if (accept_legal_s) begin
            disp_valid_r <= 1'b1;
            disp_unit_r  <= unit_s;
            disp_instr_r <= instr_i;
            buf_wr_int_r <= wr_int_s;
            buf_wr_fp_r  <= wr_fp_s;
         end else if (drain_s || flush_i) begin
            disp_valid_r <= 1'b0;
         end else begin
            disp_valid_r <= disp_valid_r;
         end
      end
   end

   assign disp_valid_o = disp_valid_r;
   assign disp_unit_o  = disp_unit_r;
   assign disp_instr_o = disp_instr_r;
   assign illegal_o    = illegal_r;

endmodule
